// File: rtl/rice_bus_pkg.sv
// rice_bus_pkg
// Shared definitions for the rice bus and its attached responders.
// The response struct itself depends on DATA_WIDTH, so each module that
// needs it declares it locally as rice_bus_response; this package only
// carries the width helper used to size strobe fields consistently.
package rice_bus_pkg;

    // One strobe bit per byte lane of the data bus.
    function automatic int strobe_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rice_bus_if.sv
// rice_bus_if
// Request/response bus between a rice core master port and a responder.
//   Request channel  (master -> slave): request_valid, address, write,
//                                       write_data, strobe
//                    (slave -> master): request_ready
//   Response channel (slave -> master): response_valid, read_data, error
//                    (master -> slave): response_ready
interface rice_bus_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) ();

    logic                                               request_valid;
    logic                                               request_ready;
    logic [ADDRESS_WIDTH-1:0]                           address;
    logic                                               write;
    logic [DATA_WIDTH-1:0]                              write_data;
    logic [rice_bus_pkg::strobe_width(DATA_WIDTH)-1:0]  strobe;

    logic                                               response_valid;
    logic                                               response_ready;
    logic [DATA_WIDTH-1:0]                              read_data;
    logic                                               error;

    modport master (
        output request_valid, address, write, write_data, strobe, response_ready,
        input  request_ready, response_valid, read_data, error
    );

    modport slave (
        input  request_valid, address, write, write_data, strobe, response_ready,
        output request_ready, response_valid, read_data, error
    );

endinterface

// File: rtl/rice_bus_memory_response_fifo.sv
// rice_bus_memory_response_fifo
// Small in-order FIFO holding responses that have been produced but not yet
// taken by the master. Pointers wrap modulo DEPTH so any DEPTH >= 2 works.
//   clk, rst_n : clock and synchronous active-low reset
//   push       : store push_data (caller never pushes when full)
//   pop        : drop the head entry (caller never pops when empty)
//   push_data  : entry to store
//   pop_data   : current head entry (meaningful only while count != 0)
//   count      : occupancy, 0..DEPTH
module rice_bus_memory_response_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]     storage [DEPTH];
    logic [PTR_WIDTH-1:0] write_ptr;
    logic [PTR_WIDTH-1:0] read_ptr;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_WIDTH-1:0] advance(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Entry storage is never cleared; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[write_ptr] <= push_data;
        end
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                write_ptr <= advance(write_ptr);
            end
            if (pop) begin
                read_ptr <= advance(read_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = storage[read_ptr];

endmodule

// File: rtl/rice_bus_memory.sv
// rice_bus_memory
// Memory responder on the slave end of rice_bus_if. Every accepted request
// produces exactly one response, returned in acceptance order through a
// small FIFO so the master can stall responses without losing throughput.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset (memory contents are kept)
//   bus_if  : rice_bus_if.slave
// Optional feature macro RICE_BUS_MEMORY_ERROR_EN: when defined, requests at
// or above SIZE_BYTES answer with error=1 and never write; when undefined,
// upper address bits are ignored and addresses alias modulo SIZE_BYTES.
module rice_bus_memory
    import rice_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SIZE_BYTES     = 4096,
    parameter int RESPONSE_DEPTH = 2
) (
    input logic        i_clk,
    input logic        i_rst_n,
    rice_bus_if.slave  bus_if
);

    localparam int STROBE_WIDTH = strobe_width(DATA_WIDTH);
    localparam int WORDS        = SIZE_BYTES / STROBE_WIDTH;
    localparam int INDEX_LSB    = $clog2(STROBE_WIDTH);
    localparam int INDEX_MSB    = $clog2(SIZE_BYTES) - 1;
    localparam int COUNT_WIDTH  = $clog2(RESPONSE_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] read_data;
        logic                  error;
    } rice_bus_response;

    logic [DATA_WIDTH-1:0]         memory [WORDS];
    logic [INDEX_MSB-INDEX_LSB:0]  word_index;
    logic                          out_of_range;
    logic                          accept;
    logic                          write_enable;
    logic                          pop;
    logic [COUNT_WIDTH-1:0]        count;
    rice_bus_response              push_response;
    rice_bus_response              head_response;
    logic                          unused_address;

    // Byte-offset bits (and, without the error feature, the upper bits)
    // take no part in addressing.
    assign unused_address = ^bus_if.address;

    assign word_index = bus_if.address[INDEX_MSB:INDEX_LSB];

`ifdef RICE_BUS_MEMORY_ERROR_EN
    localparam logic [ADDRESS_WIDTH:0] SIZE_LIMIT = (ADDRESS_WIDTH + 1)'(SIZE_BYTES);
    // Extra top bit keeps the compare valid even if SIZE_BYTES fills the address space.
    assign out_of_range = ({1'b0, bus_if.address} >= SIZE_LIMIT);
`else
    assign out_of_range = 1'b0;
`endif

    // Ready depends only on occupancy and reset, never on the master's
    // valid/ready, so no combinational loop can form through the bus.
    assign bus_if.request_ready = i_rst_n && (count < COUNT_WIDTH'(RESPONSE_DEPTH));
    assign accept               = bus_if.request_valid && bus_if.request_ready;
    assign write_enable         = accept && bus_if.write && !out_of_range;

    assign bus_if.response_valid = (count != '0);
    assign pop                   = bus_if.response_valid && bus_if.response_ready;

    // The array has no reset; only strobed lanes of in-range writes change.
    always_ff @(posedge i_clk) begin
        if (write_enable) begin
            for (int lane = 0; lane < STROBE_WIDTH; lane++) begin
                if (bus_if.strobe[lane]) begin
                    memory[word_index][lane*8 +: 8] <= bus_if.write_data[lane*8 +: 8];
                end
            end
        end
    end

    // Writes and errored requests answer with zero data.
    always_comb begin
        push_response = '0;
        if (out_of_range) begin
            push_response.error = 1'b1;
        end else if (!bus_if.write) begin
            push_response.read_data = memory[word_index];
        end
    end

    rice_bus_memory_response_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (RESPONSE_DEPTH)
    ) u_response_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (accept),
        .pop       (pop),
        .push_data (push_response),
        .pop_data  (head_response),
        .count     (count)
    );

    // Gate with valid so the outputs read zero whenever nothing is pending,
    // including straight after reset when the storage may hold stale entries.
    assign bus_if.read_data = bus_if.response_valid ? head_response.read_data : '0;
    assign bus_if.error     = bus_if.response_valid && head_response.error;

endmodule

// File: tb/tb_rice_bus_memory.sv
// tb_rice_bus_memory
// Self-checking bench for rice_bus_memory with default parameters. Requests
// are queued, driven one at a time and held until accepted; a queue of
// expected responses and a flat word array stand in for the design.
// Honours RICE_BUS_MEMORY_ERROR_EN the same way the design does.
module tb_rice_bus_memory;

    localparam int SIZE  = 4096;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] address;
        bit          write;
        logic [31:0] data;
        logic [3:0]  strobe;
    } request_t;

    typedef struct {
        logic [31:0] data;
        logic        error;
    } response_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rice_bus_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    rice_bus_memory #(
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .SIZE_BYTES     (SIZE),
        .RESPONSE_DEPTH (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_if  (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    request_t    req_q[$];
    response_t   resp_q[$];
    logic [31:0] mem_model [SIZE/4];
    bit          random_mode = 1'b0;
    logic        response_ready_level = 1'b1;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives all master-side inputs of the bus at once.
    task automatic applyStimulus(input bit valid, input request_t r, input logic resp_ready);
        bus.request_valid  = valid;
        bus.address        = r.address;
        bus.write          = r.write;
        bus.write_data     = r.data;
        bus.strobe         = r.strobe;
        bus.response_ready = resp_ready;
    endtask

    // Plain memory semantics: addresses alias modulo SIZE unless the error
    // feature flags them; writes merge strobed bytes and answer zero.
    function automatic response_t modelAccess(input request_t r);
        response_t   resp = '{data: 32'h0, error: 1'b0};
        int unsigned idx  = (r.address % SIZE) / 4;
`ifdef RICE_BUS_MEMORY_ERROR_EN
        if (r.address >= SIZE) begin
            resp.error = 1'b1;
            return resp;
        end
`endif
        if (r.write) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (r.strobe[lane]) begin
                    mem_model[idx][lane*8 +: 8] = r.data[lane*8 +: 8];
                end
            end
        end else begin
            resp.data = mem_model[idx];
        end
        return resp;
    endfunction

    // One clock: drive the head request, compare outputs against the
    // expected queue, then advance the model by what the edge should do.
    task automatic runCycle(input string tag);
        bit       drive_valid;
        bit       accepted;
        bit       popped;
        logic     resp_ready;
        request_t r;
        r           = '{address: 32'h0, write: 1'b0, data: 32'h0, strobe: 4'h0};
        drive_valid = (req_q.size() != 0);
        if (req_q.size() != 0) r = req_q[0];
        if (random_mode && ($urandom_range(0, 3) == 0)) drive_valid = 1'b0;
        resp_ready = random_mode ? 1'($urandom_range(0, 1)) : response_ready_level;
        applyStimulus(drive_valid, r, resp_ready);
        #1;
        checkOutput({tag, " request_ready"}, 64'(bus.request_ready), 64'(resp_q.size() < DEPTH));
        checkOutput({tag, " response_valid"}, 64'(bus.response_valid), 64'(resp_q.size() != 0));
        if (resp_q.size() != 0) begin
            checkOutput({tag, " read_data"}, 64'(bus.read_data), 64'(resp_q[0].data));
            checkOutput({tag, " error"}, 64'(bus.error), 64'(resp_q[0].error));
        end
        accepted = drive_valid && (resp_q.size() < DEPTH);
        popped   = (resp_q.size() != 0) && resp_ready;
        @(posedge clk);
        if (popped) void'(resp_q.pop_front());
        if (accepted) begin
            resp_q.push_back(modelAccess(r));
            void'(req_q.pop_front());
        end
        #1;
    endtask

    // Runs until everything queued has been issued and answered, bounded.
    task automatic drain(input string tag, input int budget);
        while ((req_q.size() != 0 || resp_q.size() != 0) && budget > 0) begin
            runCycle(tag);
            budget--;
        end
        checkOutput({tag, " pending at end"}, 64'(req_q.size() + resp_q.size()), 64'(0));
        req_q.delete();
        resp_q.delete();
    endtask

    // One reset cycle, optionally with a write presented that must not land.
    task automatic applyReset(input bit with_write);
        request_t r;
        r     = '{address: 32'h10, write: 1'b1, data: 32'hBAD0BAD0, strobe: 4'hF};
        rst_n = 1'b0;
        applyStimulus(with_write, r, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset response_valid", 64'(bus.response_valid), 64'(0));
        checkOutput("reset request_ready", 64'(bus.request_ready), 64'(0));
        checkOutput("reset read_data", 64'(bus.read_data), 64'(0));
        checkOutput("reset error", 64'(bus.error), 64'(0));
        resp_q.delete();
        rst_n = 1'b1;
        r.write = 1'b0;
        applyStimulus(1'b0, r, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case anything above runs away.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    // Directed scenarios first, then a randomized soak against the model.
    initial begin
        request_t r;
        r = '{address: 32'h0, write: 1'b0, data: 32'h0, strobe: 4'h0};
        applyStimulus(1'b0, r, 1'b1);
        @(posedge clk);
        applyReset(1'b0);

        $display("[TB] single write then read");
        req_q.push_back('{32'h10, 1'b1, 32'hDEADBEEF, 4'hF});
        req_q.push_back('{32'h10, 1'b0, 32'h0, 4'h0});
        drain("write_read", 50);

        $display("[TB] byte strobe merge");
        req_q.push_back('{32'h20, 1'b1, 32'h11223344, 4'hF});
        req_q.push_back('{32'h20, 1'b1, 32'hAABBCCDD, 4'h5});
        req_q.push_back('{32'h20, 1'b0, 32'h0, 4'h0});
        req_q.push_back('{32'h23, 1'b0, 32'h0, 4'h0});
        drain("byte_strobe", 50);

        $display("[TB] back-to-back reads");
        for (int i = 0; i < 8; i++) begin
            req_q.push_back('{(i % 2 == 0) ? 32'h10 : 32'h20, 1'b0, 32'h0, 4'h0});
        end
        drain("back_to_back", 50);

        $display("[TB] backpressure");
        response_ready_level = 1'b0;
        req_q.push_back('{32'h10, 1'b0, 32'h0, 4'h0});
        req_q.push_back('{32'h20, 1'b0, 32'h0, 4'h0});
        req_q.push_back('{32'h11, 1'b0, 32'h0, 4'h0});
        req_q.push_back('{32'h22, 1'b0, 32'h0, 4'h0});
        repeat (4) runCycle("backpressure_hold");
        response_ready_level = 1'b1;
        drain("backpressure_release", 50);

        $display("[TB] reset mid-stream");
        response_ready_level = 1'b0;
        req_q.push_back('{32'h10, 1'b0, 32'h0, 4'h0});
        req_q.push_back('{32'h20, 1'b0, 32'h0, 4'h0});
        repeat (2) runCycle("reset_fill");
        applyReset(1'b1);
        response_ready_level = 1'b1;
        req_q.push_back('{32'h10, 1'b0, 32'h0, 4'h0});
        req_q.push_back('{32'h20, 1'b0, 32'h0, 4'h0});
        drain("after_reset", 50);

        $display("[TB] upper address handling");
        req_q.push_back('{32'h0, 1'b1, 32'h01234567, 4'hF});
        req_q.push_back('{32'h1000, 1'b1, 32'h5555AAAA, 4'hF});
        req_q.push_back('{32'h1000, 1'b0, 32'h0, 4'h0});
        req_q.push_back('{32'h0, 1'b0, 32'h0, 4'h0});
        drain("upper_address", 50);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 16; i++) begin
            req_q.push_back('{32'(i * 4), 1'b1, $urandom, 4'hF});
        end
        drain("random_init", 100);
        random_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            r.address = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) r.address = r.address + 32'h1000 * 32'($urandom_range(1, 3));
            r.write  = 1'($urandom_range(0, 1));
            r.data   = $urandom;
            r.strobe = 4'($urandom_range(0, 15));
            req_q.push_back(r);
        end
        drain("random", 3000);
        random_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rice_bus_memory.md
# rice_bus_memory

Bus-attached memory responder: the slave end of `rice_bus_if`, serving the instruction and data requests issued by the rice core's master ports. It holds a byte-addressable word array and answers each accepted request with exactly one in-order response. A small response FIFO provides backpressure tolerance and one-transfer-per-cycle throughput. It is instantiated in the testbench and SoC top alongside the core, one per bus.

## Interface
- `ADDRESS_WIDTH`, default 32: bus address width.
- `DATA_WIDTH`, default 32: bus data width; must be a multiple of 8.
- `SIZE_BYTES`, default 4096: memory size in bytes; must be a power of two and ≥ DATA_WIDTH/8.
- `RESPONSE_DEPTH`, default 2: response FIFO entries; must be ≥ 2.
- `i_clk`, input, 1: the single clock.
- `i_rst_n`, input, 1: synchronous, active-low reset.
- `bus_if`, `rice_bus_if.slave`, interface.
  - Request channel from master: `request_valid`, `request_ready`, `address`, `write`, `write_data`, `strobe` (DATA_WIDTH/8 bits).
  - Response channel to master: `response_valid`, `response_ready`, `read_data`, `error`.

## Operation
- **Request acceptance:** a request is accepted in any cycle where `request_valid && request_ready`.
- **Ready rule:** `request_ready = (count < RESPONSE_DEPTH)`.
  - `count` is FIFO occupancy, 0..RESPONSE_DEPTH.
  - `request_ready` has no combinational path from `response_ready` or `request_valid`.
- **Word index:** `address[$clog2(SIZE_BYTES)-1 : $clog2(DATA_WIDTH/8)]`. Low byte-offset bits are ignored.
- **Accepted write:** each byte lane with `strobe[i]=1` is updated at the accepting edge. The pushed response is `read_data=0`, `error=0`.
- **Accepted read:** the word is read at the accepting edge and pushed into the FIFO with `error=0`.
- **Read-after-write:** a read accepted in cycle N+1 returns data written in cycle N.
- **Response output:**
  - `response_valid = (count != 0)`.
  - `read_data` and `error` come from the FIFO head.
  - The head pops when `response_valid && response_ready`.
- **Counter update:**
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - Push never occurs at `count == RESPONSE_DEPTH`, because ready is low.
- **FIFO pointers:** read and write pointers wrap modulo RESPONSE_DEPTH. Responses are strictly in acceptance order.
- **Stalled response:** while `response_valid && !response_ready`, the head data is held stable.

## Timing
- **Latency:** a request accepted in cycle N gives `response_valid=1` in cycle N+1, provided the FIFO was empty.
- **Throughput:** with `response_ready` held high, one request is accepted and one response is returned per cycle, sustained.
- **Backpressure:** with `response_ready=0`, exactly RESPONSE_DEPTH requests are accepted, then `request_ready` drops.
  - `request_ready` reasserts the cycle after the first pop.
- **While `i_rst_n=0` (sampled at edge):**
  - `count`, FIFO pointers and outputs are cleared.
  - `response_valid=0`, `request_ready=0`, `read_data=0`, `error=0`.
- **After reset deasserts:** `request_ready=1` in the first cycle.
- **Reset mid-operation:** pending responses are discarded. A write accepted in the same cycle as active reset is not performed.
- **Memory contents:** the array is not reset.

## Configuration
- Macro: `RICE_BUS_MEMORY_ERROR_EN`.
- **Defined:**
  - A request with `address >= SIZE_BYTES` is accepted normally.
  - It performs no write and gets a response with `error=1`, `read_data=0`.
  - Latency and ordering are unchanged.
- **Undefined:**
  - Upper address bits are ignored; addresses alias modulo SIZE_BYTES.
  - `error` is tied to 0.

## Structure
- **Shared package `rice_bus_pkg`:**
  - `rice_bus_response` struct {`read_data`, `error`}, parameterised by DATA_WIDTH via typedef in the module.
  - Strobe-width helper function.
- **Sub-module `rice_bus_memory_response_fifo`:**
  - Holds the response FIFO: storage, pointers, count.
  - Ports: push, pop, data in/out, `count`.
- **Top level:** memory array, write-enable decode, address check, ready logic.

## Test plan
- **Single write then read:** write 0xDEADBEEF to 0x10, strobe 0xF; read 0x10 → read response 0xDEADBEEF, error 0, valid in cycle N+1 after acceptance.
- **Byte strobe:** write 0x11223344 to 0x20, then write 0xAABBCCDD with strobe 0x5; read 0x20 → 0x11BB33DD.
- **Back-to-back:** 8 consecutive reads with `response_ready=1` → 8 responses on 8 consecutive cycles, in order, `request_ready` never low.
- **Backpressure:** `response_ready=0`, issue 4 requests → exactly 2 accepted, `request_ready=0`. Raise `response_ready` → `request_ready=1` the next cycle; all 4 responses in order.
- **Reset mid-stream:** 2 responses pending, assert `i_rst_n=0` one cycle → `response_valid=0`, `count=0`, previously written memory data still readable afterwards.
- **Error (`RICE_BUS_MEMORY_ERROR_EN` defined, SIZE_BYTES=4096):** write to 0x1000, then read 0x1000 → error 1, data 0. Read 0x0 → unchanged contents, error 0.
